// File: rtl/if_fetch.sv
// Instruction fetch unit with prefetch buffer; optional bubble counter under IF_FETCH_PERF_CNT_EN.
// Latency: a response reaches inst_o the cycle after rvalid; a redirect PC is driven the next cycle.
// Backpressure: stall_i holds the head; requests pause while buffered + outstanding reach BUF_DEPTH.

// Generic flushable FIFO exposing its head entry.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: none internally; the owner must not push when full.
module if_fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] head_dat,
    output logic [CW-1:0]    cnt
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push_vld & ~flush;
    assign do_pop   = pop_rdy & ~flush & (cnt != '0);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

module if_fetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                    BUF_DEPTH  = 2,
    parameter logic [DATA_WIDTH-1:0] NOP        = 32'h0000_0013
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  imem_req_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic [ADDR_WIDTH-1:0] inst_addr_o,
    output logic [DATA_WIDTH-1:0] inst_o,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_addr_i
`ifdef IF_FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           bubble_cnt_o
`endif
);
    localparam int CW  = $clog2(BUF_DEPTH + 1);
    localparam int CW1 = CW + 1;
    localparam logic [CW1-1:0]        LIMIT   = CW1'(BUF_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

    typedef enum logic {RUN, DISCARD} state_t;

    state_t                           state_q;
    logic [CW-1:0]                    disc_q;
    logic [CW-1:0]                    disc_nxt;
    logic [CW-1:0]                    buf_cnt;
    logic [CW-1:0]                    oq_cnt;
    logic [ADDR_WIDTH-1:0]            pc_q;
    logic [ADDR_WIDTH-1:0]            oq_head;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] buf_head;
    logic                             fire;
    logic                             buf_push;
    logic                             buf_pop;
    logic                             buf_vld;

    assign imem_req_o  = rst_i & (({1'b0, buf_cnt} + {1'b0, oq_cnt}) < LIMIT);
    assign imem_addr_o = pc_q;
    assign fire        = imem_req_o & imem_gnt_i;
    assign buf_push    = imem_rvalid_i & (state_q == RUN) & ~redirect_i;
    assign buf_vld     = (buf_cnt != '0);
    assign buf_pop     = ~stall_i & ~redirect_i & buf_vld;
    // Every in-flight request becomes stale on redirect. A response arriving this
    // cycle retires one of them whether it was kept (RUN) or dropped (DISCARD).
    assign disc_nxt    = oq_cnt + CW'(fire) - CW'(imem_rvalid_i);

    assign inst_o      = buf_vld ? buf_head[DATA_WIDTH-1:0] : NOP;
    assign inst_addr_o = buf_vld ? buf_head[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH] : '0;

    if_fetch_fifo #(.WIDTH(ADDR_WIDTH + DATA_WIDTH), .DEPTH(BUF_DEPTH), .CW(CW)) u_buf (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .flush    (redirect_i),
        .push_vld (buf_push),
        .push_dat ({oq_head, imem_rdata_i}),
        .pop_rdy  (buf_pop),
        .head_dat (buf_head),
        .cnt      (buf_cnt)
    );

    if_fetch_fifo #(.WIDTH(ADDR_WIDTH), .DEPTH(BUF_DEPTH), .CW(CW)) u_oq (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .flush    (1'b0),
        .push_vld (fire),
        .push_dat (pc_q),
        .pop_rdy  (imem_rvalid_i),
        .head_dat (oq_head),
        .cnt      (oq_cnt)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)          pc_q <= RESET_PC;
        else if (redirect_i) pc_q <= {redirect_addr_i[ADDR_WIDTH-1:2], 2'b00};
        else if (fire)       pc_q <= pc_q + PC_STEP;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= RUN;
            disc_q  <= '0;
        end else if (redirect_i) begin
            disc_q  <= disc_nxt;
            state_q <= (disc_nxt != '0) ? DISCARD : RUN;
        end else if (state_q == DISCARD && imem_rvalid_i) begin
            disc_q <= disc_q - CW'(1);
            if (disc_q == CW'(1)) state_q <= RUN;
        end
    end

`ifdef IF_FETCH_PERF_CNT_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)                                 bubble_cnt_o <= '0;
        else if (~stall_i & ~redirect_i & ~buf_vld) bubble_cnt_o <= bubble_cnt_o + 32'd1;
    end
`endif

`ifndef SYNTHESIS
    rsp_without_req: assert property (@(posedge clk_i) disable iff (!rst_i)
        imem_rvalid_i |-> (oq_cnt != '0))
        else $error("if_fetch: imem response with no request outstanding");
`endif
endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch (BUF_DEPTH=2): vector table for free-run, hand sequences for corners.
module tb_if_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic [31:0] inst_addr_o;
    logic [31:0] inst_o;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_addr_i = '0;
`ifdef IF_FETCH_PERF_CNT_EN
    logic [31:0] bubble_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    if_fetch #(.BUF_DEPTH(2)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_gnt_i      (imem_gnt_i),
        .imem_rvalid_i   (imem_rvalid_i),
        .imem_rdata_i    (imem_rdata_i),
        .inst_addr_o     (inst_addr_o),
        .inst_o          (inst_o),
        .stall_i         (stall_i),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i)
`ifdef IF_FETCH_PERF_CNT_EN
        ,
        .bubble_cnt_o    (bubble_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        stall;
        logic        redir;
        logic        gnt;
        logic        rvalid;
        logic [31:0] raddr;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic [31:0] iaddr;
        logic [31:0] inst;
    } vec_t;

    vec_t tv [10];

    function automatic logic [31:0] x(input logic [31:0] a);
        return a ^ 32'hA5A5_A5A5;
    endfunction

    function automatic vec_t mk(input logic g, input logic rv, input logic [31:0] rd,
                                input logic rq, input logic [31:0] ad,
                                input logic [31:0] ia, input logic [31:0] in);
        vec_t v;
        v.stall = 1'b0; v.redir = 1'b0; v.raddr = '0;
        v.gnt = g; v.rvalid = rv; v.rdata = rd;
        v.req = rq; v.addr = ad; v.iaddr = ia; v.inst = in;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic exp4(input string tag, input logic rq, input logic [31:0] ad,
                        input logic [31:0] ia, input logic [31:0] in);
        chk({tag, " req"}, {31'b0, imem_req_o}, {31'b0, rq});
        chk({tag, " addr"}, imem_addr_o, ad);
        chk({tag, " inst_addr"}, inst_addr_o, ia);
        chk({tag, " inst"}, inst_o, in);
    endtask

    // Drive one cycle's inputs just after the rising edge and settle at the falling edge.
    task automatic cyc(input logic st, input logic rd, input logic [31:0] ra,
                       input logic g, input logic rv, input logic [31:0] rdat);
        stall_i = st; redirect_i = rd; redirect_addr_i = ra;
        imem_gnt_i = g; imem_rvalid_i = rv; imem_rdata_i = rdat;
        @(negedge clk_i);
    endtask

    task automatic adv();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst_i = 1'b0;
        stall_i = 1'b0; redirect_i = 1'b0; redirect_addr_i = '0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        exp4(tag, 1'b0, 32'h0, 32'h0, NOP);
`ifdef IF_FETCH_PERF_CNT_EN
        chk({tag, " bubble"}, bubble_cnt_o, 32'd0);
`endif
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
    endtask

    initial begin
        // Free run, gnt held high, rvalid one cycle after each grant.
        tv[0] = mk(1, 0, 0,        1, 32'd0,  32'd0,  NOP);
        tv[1] = mk(1, 1, x(0),     1, 32'd4,  32'd0,  NOP);
        tv[2] = mk(1, 1, x(4),     0, 32'd8,  32'd0,  x(0));
        tv[3] = mk(1, 0, 0,        1, 32'd8,  32'd4,  x(4));
        tv[4] = mk(1, 1, x(8),     1, 32'd12, 32'd0,  NOP);
        tv[5] = mk(1, 1, x(12),    0, 32'd16, 32'd8,  x(8));
        tv[6] = mk(1, 0, 0,        1, 32'd16, 32'd12, x(12));
        tv[7] = mk(1, 1, x(16),    1, 32'd20, 32'd0,  NOP);
        tv[8] = mk(1, 1, x(20),    0, 32'd24, 32'd16, x(16));
        tv[9] = mk(1, 0, 0,        1, 32'd24, 32'd20, x(20));

        do_reset("rst0");
        for (int i = 0; i < 10; i++) begin
            cyc(tv[i].stall, tv[i].redir, tv[i].raddr, tv[i].gnt, tv[i].rvalid, tv[i].rdata);
            exp4($sformatf("tv%0d", i), tv[i].req, tv[i].addr, tv[i].iaddr, tv[i].inst);
            adv();
        end

        // Reset with request 24 still outstanding; it is never answered.
        do_reset("rst1");
        cyc(1, 0, 0, 1, 0, 0);         exp4("stl0", 1, 32'h0,  32'h0, NOP);   adv();
        cyc(1, 0, 0, 1, 1, x(0));      exp4("stl1", 1, 32'h4,  32'h0, NOP);   adv();
        cyc(1, 0, 0, 1, 1, x(4));      exp4("stl2", 0, 32'h8,  32'h0, x(0));  adv();
        cyc(1, 0, 0, 1, 0, 0);         exp4("stl3", 0, 32'h8,  32'h0, x(0));  adv();
        cyc(1, 0, 0, 1, 0, 0);         exp4("stl4", 0, 32'h8,  32'h0, x(0));  adv();
        cyc(0, 0, 0, 1, 0, 0);         exp4("stl5", 0, 32'h8,  32'h0, x(0));  adv();
        cyc(0, 0, 0, 1, 0, 0);         exp4("stl6", 1, 32'h8,  32'h4, x(4));  adv();
        cyc(0, 0, 0, 1, 1, x(8));      exp4("stl7", 1, 32'hC,  32'h0, NOP);   adv();
        cyc(1, 1, 32'h40, 0, 0, 0);    exp4("stl8", 0, 32'h10, 32'h8, x(8));  adv();
        cyc(0, 0, 0, 0, 0, 0);         exp4("stl9", 1, 32'h40, 32'h0, NOP);   adv();

        // Redirect with two requests outstanding: both responses must be dropped.
        do_reset("rst2");
        cyc(0, 0, 0, 1, 0, 0);              exp4("rd0", 1, 32'h0,   32'h0,   NOP);      adv();
        cyc(0, 0, 0, 1, 0, 0);              exp4("rd1", 1, 32'h4,   32'h0,   NOP);      adv();
        cyc(0, 1, 32'h103, 1, 0, 0);        exp4("rd2", 0, 32'h8,   32'h0,   NOP);      adv();
        cyc(0, 0, 0, 1, 1, x(0));           exp4("rd3", 0, 32'h100, 32'h0,   NOP);      adv();
        cyc(0, 0, 0, 1, 1, x(4));           exp4("rd4", 1, 32'h100, 32'h0,   NOP);      adv();
        cyc(0, 0, 0, 1, 1, x(32'h100));     exp4("rd5", 1, 32'h104, 32'h0,   NOP);      adv();
        cyc(0, 0, 0, 1, 1, x(32'h104));     exp4("rd6", 0, 32'h108, 32'h100, x(32'h100)); adv();
        cyc(0, 0, 0, 0, 0, 0);              exp4("rd7", 1, 32'h108, 32'h104, x(32'h104)); adv();

        // Redirect coinciding with rvalid and a grant of the old PC.
        do_reset("rst3");
        cyc(0, 0, 0, 1, 0, 0);              exp4("rg0", 1, 32'h0,   32'h0,   NOP);      adv();
        cyc(0, 1, 32'h200, 1, 1, x(0));     exp4("rg1", 1, 32'h4,   32'h0,   NOP);      adv();
        cyc(0, 0, 0, 1, 1, x(4));           exp4("rg2", 1, 32'h200, 32'h0,   NOP);      adv();
        cyc(0, 0, 0, 1, 1, x(32'h200));     exp4("rg3", 1, 32'h204, 32'h0,   NOP);      adv();
        cyc(0, 0, 0, 1, 1, x(32'h204));     exp4("rg4", 0, 32'h208, 32'h200, x(32'h200)); adv();
        cyc(0, 0, 0, 0, 0, 0);              exp4("rg5", 1, 32'h208, 32'h204, x(32'h204)); adv();

        // PC wrap at the top of the address space.
        do_reset("rst4");
        cyc(0, 1, 32'hFFFF_FFF8, 0, 0, 0);  exp4("wr0", 1, 32'h0,         32'h0,         NOP);           adv();
        cyc(0, 0, 0, 1, 0, 0);              exp4("wr1", 1, 32'hFFFF_FFF8, 32'h0,         NOP);           adv();
        cyc(0, 0, 0, 1, 1, x(32'hFFFF_FFF8)); exp4("wr2", 1, 32'hFFFF_FFFC, 32'h0,       NOP);           adv();
        cyc(0, 0, 0, 1, 1, x(32'hFFFF_FFFC)); exp4("wr3", 0, 32'h0, 32'hFFFF_FFF8, x(32'hFFFF_FFF8)); adv();
        cyc(0, 0, 0, 1, 0, 0);              exp4("wr4", 1, 32'h0, 32'hFFFF_FFFC, x(32'hFFFF_FFFC)); adv();
        cyc(0, 0, 0, 1, 1, x(0));           exp4("wr5", 1, 32'h4,         32'h0,         NOP);           adv();
        cyc(0, 0, 0, 0, 1, x(4));           exp4("wr6", 0, 32'h8,         32'h0,         x(0));          adv();

        // Grant withheld three cycles: request and address hold, bubbles counted.
        do_reset("rst5");
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, (i == 3), 0, 0);
            exp4($sformatf("gw%0d", i), 1, 32'h0, 32'h0, NOP);
`ifdef IF_FETCH_PERF_CNT_EN
            chk($sformatf("gw%0d bubble", i), bubble_cnt_o, i);
`endif
            adv();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
